press_pulse_gen: RTL
====================

Name: press_pulse_gen

Overview:
- Converts single-cycle request ticks into press-shaped level waveforms: a clean high for a fixed hold time, then a guaranteed low gap.
- The output meets the team's four-stage falling-edge press detector. Each accepted request yields exactly one detector tick.
- Used for built-in self-test and simulated key presses on the button-control path.
- Buffers bursts of requests in a pending counter and reports overflow.

Parameters:
- HOLD_CYCLES, 6, cycles levelr is held high per press; must be >= 4.
- GAP_CYCLES, 4, cycles levelr is held low after each press; must be >= 1.
- PEND_W, 3, width of the pending-request counter; capacity is 2^PEND_W-1 (7).

Ports:
- clkr  in  1  system clock, rising edge.
- rstr_n  in  1  asynchronous active-low reset.
- reqr  in  1  one-cycle request tick; a high level on consecutive cycles counts as one request per cycle.
- enr  in  1  enable for starting new presses.
- clr_ovfr  in  1  one-cycle clear of ovfr.
- levelr  out  1  generated press level, registered.
- busyr  out  1  high while a press or gap is in progress.
- pendr  out  PEND_W  number of queued, not-yet-started requests.
- ovfr  out  1  sticky flag: a request was dropped because the queue was full.

Behaviour:
- Reset (asynchronous, rstr_n=0): levelr=0, busyr=0, pendr=0, ovfr=0, state=IDLE, phase counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- The phase counter is sized to hold max(HOLD_CYCLES, GAP_CYCLES).
- State IDLE:
  - levelr=0, busyr=0.
  - Start condition: enr=1 and (pendr>0 or reqr=1).
  - On start: next edge enters HIGH, levelr=1, phase counter loads 1.
  - If start uses a queued request, pendr decrements.
  - If pendr=0 and reqr=1, the request starts directly and pendr is unchanged.
  - Latency: a reqr sampled at edge k in IDLE with enr=1 gives levelr=1 after edge k.
- State HIGH:
  - levelr=1 for exactly HOLD_CYCLES clock cycles.
  - On the last HIGH cycle, the next edge enters GAP with levelr=0.
- State GAP:
  - levelr=0 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle, if enr=1 and (pendr>0 or reqr=1), the next edge enters HIGH directly, consuming one request. Back-to-back presses therefore have exactly GAP_CYCLES low cycles between them.
  - Otherwise the next edge enters IDLE.
- busyr=1 in HIGH and GAP.
- Queue accounting (every edge):
  - An incoming reqr not consumed by a start increments pendr, if pendr < 2^PEND_W-1.
  - If the queue is full, the request is dropped and ovfr is set.
  - reqr and a dequeue on the same edge: pendr is unchanged.
  - Arriving requests count in every state; pendr never wraps.
- enr=0:
  - A press in progress completes its full HIGH and GAP phases.
  - No new press starts; requests still queue.
  - Raising enr in IDLE with pendr>0 starts a press at the next edge.
- ovfr:
  - Sticky; cleared by clr_ovfr.
  - If clr_ovfr and an overflow occur on the same edge, ovfr stays 1 (set wins).
- Reset mid-operation: levelr drops to 0 immediately (asynchronous), all pending requests are discarded, and the first edge after release starts from IDLE.
- Parameter violations (HOLD_CYCLES<4 or GAP_CYCLES<1) are flagged by a simulation-time error.

Test Plan:
- Single request: idle with enr=1, one reqr pulse at edge k -> levelr high for edges k..k+5 (6 cycles), low for 4 cycles, then busyr=0. pendr stays 0 throughout. Loopback detector reports exactly 1 tick.
- Burst of 3: reqr high for 3 consecutive cycles -> pendr shows 0,1,2 then decrements as presses start. Output is 3 presses of 6 high / 4 low, with no extra idle cycle between them. Detector counts 3 ticks. ovfr=0.
- Overflow: enr=0 and 9 reqr pulses -> pendr saturates at 7 and ovfr=1. Raising enr produces exactly 7 presses. clr_ovfr then gives ovfr=0. clr_ovfr on the same edge as a dropped request -> ovfr stays 1.
- Enable drop: enr deasserted during the 2nd HIGH cycle of a press with pendr=2 -> that press completes its 6+4 cycles, then IDLE with pendr=2. Re-asserting enr starts the next press on the following edge.
- Reset mid-press: rstr_n low during the 3rd HIGH cycle with pendr=4 -> levelr=0 within the same cycle, and pendr=0, busyr=0, ovfr=0. No press resumes after release.
- Request at GAP end: reqr asserted on the last GAP cycle with pendr=0 -> HIGH entered on the next edge and pendr stays 0.

Source files
------------

// File: rtl/press_pulse_gen.sv
// Press waveform generator: turns request ticks into a clean high hold followed
// by a guaranteed low gap, with a saturating pending-request queue.
//
// state  | meaning
// S_IDLE | levelr low, waiting for enr and a request
// S_HIGH | levelr high for HOLD_CYCLES
// S_GAP  | levelr low for GAP_CYCLES, may chain straight into the next press
module press_pulse_gen #(
  parameter int HOLD_CYCLES = 6,
  parameter int GAP_CYCLES  = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clkr,
  input  logic              rstr_n,
  input  logic              reqr,
  input  logic              enr,
  input  logic              clr_ovfr,
  output logic              levelr,
  output logic              busyr,
  output logic [PEND_W-1:0] pendr,
  output logic              ovfr
);

  localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]   HOLD_TC   = PH_W'(HOLD_CYCLES);
  localparam logic [PH_W-1:0]   GAP_TC    = PH_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_FULL = '1;

  generate
    if (HOLD_CYCLES < 4 || GAP_CYCLES < 1) begin : g_param_err
      $error("press_pulse_gen: HOLD_CYCLES must be >= 4 and GAP_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, busy_q;
  logic              have_work, start, enq, deq;

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    start     = 1'b0;
    have_work = enr && ((pend_q != '0) || reqr);
    case (state_q)
      S_IDLE: begin
        if (have_work) begin
          start   = 1'b1;
          state_d = S_HIGH;
          ph_d    = PH_W'(1);
        end
      end
      S_HIGH: begin
        if (ph_q == HOLD_TC) begin
          state_d = S_GAP;
          ph_d    = PH_W'(1);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_GAP: begin
        if (ph_q == GAP_TC) begin
          if (have_work) begin
            start   = 1'b1;
            state_d = S_HIGH;
            ph_d    = PH_W'(1);
          end else begin
            state_d = S_IDLE;
            ph_d    = '0;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase

    // A start with an empty queue consumes the incoming request directly.
    deq    = start && (pend_q != '0);
    enq    = reqr && !(start && (pend_q == '0));
    pend_d = pend_q;
    ovf_d  = clr_ovfr ? 1'b0 : ovf_q;
    if (enq && !deq) begin
      if (pend_q != PEND_FULL) pend_d = pend_q + PEND_W'(1);
      else                     ovf_d  = 1'b1;
    end else if (!enq && deq) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clkr or negedge rstr_n) begin
    if (!rstr_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= (state_d == S_HIGH);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign levelr = level_q;
  assign busyr  = busy_q;
  assign pendr  = pend_q;
  assign ovfr   = ovf_q;

endmodule
